skolem_sweep_checker: RTL and testbench

- Sequential exhaustive checker placed directly around a combinational Skolem-function netlist (e.g. an ABC-generated SKOLEMFORMULA block).
- Drives every universal-input assignment into the netlist and consumes the netlist's specification-satisfied result, one vector per clock.
- Reports pass/fail, the failure count and the first counterexample vector.
- Used on the bench and on FPGA to validate generated Skolem functions for the plogic-to-bitvector flow.

---
 rtl/skolem_sweep_checker.sv | 199 +++++++++++++++++++
 tb/tb_skolem_sweep_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_sweep_checker.sv
// skolem_sweep_checker
// Sweeps every universal-input assignment through a combinational Skolem
// netlist, one vector per clock, and reports pass/fail, a saturating failure
// count and the first counterexample.
// Optional build macro: SWEEP_STOP_ON_FAIL_EN (end the sweep at the first
// failing sample instead of counting every failure).
module skolem_sweep_checker #(
  parameter int N_IN = 8,
  parameter int LAT  = 0,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            skolem_in,
  input  logic            spec_ok,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   fail_count,
  output logic [N_IN-1:0] cex_vec,
  output logic            cex_skolem
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [N_IN-1:0] VEC_LAST   = '1;
  localparam logic [CW-1:0]   CNT_MAX    = '1;
  localparam logic [2:0]      DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [2:0]      drain_q, drain_d;
  logic [CW-1:0]   fail_q, fail_d;
  logic [N_IN-1:0] cex_vec_q, cex_vec_d;
  logic            cex_sk_q, cex_sk_d;
  logic            pass_q, pass_d;

  logic            in_sweep;
  logic            accept;
  logic            sample;
  logic            fail_hit;
  logic            halt;      // sweep cut short by an early failure
  logic            dly_valid; // delayed issue flag, aligned with spec_ok
  logic [N_IN-1:0] dly_vec;   // delayed vector, aligned with spec_ok

`ifdef SWEEP_STOP_ON_FAIL_EN
  logic stop_q, stop_d;
  assign halt = stop_q;
`else
  assign halt = 1'b0;
`endif

  assign in_sweep = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sample   = dly_valid && in_sweep && !halt;
  assign fail_hit = sample && !spec_ok;

  // Delay line: carries (valid, vector) so each spec_ok is matched with the
  // vector that produced it LAT cycles earlier. A new sweep or an early stop
  // flushes whatever is still in flight.
  generate
    if (LAT == 0) begin : g_nodly
      assign dly_valid = (state_q == S_ISSUE);
      assign dly_vec   = vec_q;
    end else begin : g_dly
      genvar gi;
      for (gi = 0; gi < LAT; gi++) begin : g_stage
        logic            v_q;
        logic [N_IN-1:0] d_q;
        logic            v_in;
        logic [N_IN-1:0] d_in;
        if (gi == 0) begin : g_head
          assign v_in = (state_q == S_ISSUE);
          assign d_in = vec_q;
        end else begin : g_tail
          assign v_in = g_stage[gi-1].v_q;
          assign d_in = g_stage[gi-1].d_q;
        end
        // One pipeline stage; cleared on reset, new sweep or early stop.
        always_ff @(posedge clk) begin
          if (rst || accept || halt) begin
            v_q <= 1'b0;
            d_q <= '0;
          end else begin
            v_q <= v_in;
            d_q <= d_in;
          end
        end
      end
      assign dly_valid = g_stage[LAT-1].v_q;
      assign dly_vec   = g_stage[LAT-1].d_q;
    end
  endgenerate

  // Next-state logic: sweep sequencing plus sample capture.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    drain_d   = drain_q;
    fail_d    = fail_q;
    cex_vec_d = cex_vec_q;
    cex_sk_d  = cex_sk_q;
    pass_d    = pass_q;
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop_d    = fail_hit;
`endif

    if (fail_hit) begin
      if (fail_q != CNT_MAX) begin
        fail_d = fail_q + CW'(1);
      end
      // Count never returns to zero within a sweep, so zero marks "no failure yet".
      if (fail_q == '0) begin
        cex_vec_d = dly_vec;
        cex_sk_d  = skolem_in;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ISSUE;
          vec_d     = '0;
          drain_d   = '0;
          fail_d    = '0;
          cex_vec_d = '0;
          cex_sk_d  = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (vec_q == VEC_LAST) begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          vec_d = vec_q + N_IN'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SWEEP_STOP_ON_FAIL_EN
    if (halt && in_sweep) begin
      state_d = S_DONE;
      vec_d   = vec_q;
      drain_d = drain_q;
    end
`endif

    // Verdict is latched on the way into DONE, including the final sample.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      pass_d = (fail_d == '0);
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      drain_q   <= '0;
      fail_q    <= '0;
      cex_vec_q <= '0;
      cex_sk_q  <= 1'b0;
      pass_q    <= 1'b0;
`ifdef SWEEP_STOP_ON_FAIL_EN
      stop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      drain_q   <= drain_d;
      fail_q    <= fail_d;
      cex_vec_q <= cex_vec_d;
      cex_sk_q  <= cex_sk_d;
      pass_q    <= pass_d;
`ifdef SWEEP_STOP_ON_FAIL_EN
      stop_q    <= stop_d;
`endif
    end
  end

  assign vec_out    = vec_q;
  assign busy       = in_sweep;
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign cex_vec    = cex_vec_q;
  assign cex_skolem = cex_sk_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Bench for skolem_sweep_checker: three instances (LAT 0/2/1, one with a tiny
// saturating counter) run in lockstep against table-driven netlist models.
module tb_skolem_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;

  logic [7:0]  vec_a, vec_b, cex_a, cex_b;
  logic [4:0]  vec_c, cex_c;
  logic [15:0] fc_a, fc_b;
  logic [2:0]  fc_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic pass_a, pass_b, pass_c, csk_a, csk_b, csk_c;
  logic ok_a, ok_b, ok_c, sk_a, sk_b, sk_c;

  // Netlist models: a truth table per instance, plus the netlist's own latency.
  bit fail_t [3][256];
  bit sk_t   [3][256];
  logic [7:0] pb1 = '0, pb2 = '0;
  logic [4:0] pc1 = '0;
  always @(posedge clk) begin
    pb1 <= vec_b;
    pb2 <= pb1;
    pc1 <= vec_c;
  end
  assign ok_a = ~fail_t[0][vec_a];
  assign sk_a = sk_t[0][vec_a];
  assign ok_b = ~fail_t[1][pb2];
  assign sk_b = sk_t[1][pb2];
  assign ok_c = ~fail_t[2][pc1];
  assign sk_c = sk_t[2][pc1];

  skolem_sweep_checker #(.N_IN(8), .LAT(0), .CW(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_a), .skolem_in(sk_a),
    .spec_ok(ok_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a), .cex_vec(cex_a), .cex_skolem(csk_a));

  skolem_sweep_checker #(.N_IN(8), .LAT(2), .CW(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_b), .skolem_in(sk_b),
    .spec_ok(ok_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .cex_vec(cex_b), .cex_skolem(csk_b));

  skolem_sweep_checker #(.N_IN(5), .LAT(1), .CW(3)) dut_c (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_c), .skolem_in(sk_c),
    .spec_ok(ok_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_count(fc_c), .cex_vec(cex_c), .cex_skolem(csk_c));

  int n_of   [3] = '{256, 256, 32};
  int lat_of [3] = '{0, 2, 1};
  int cmax_of[3] = '{65535, 65535, 7};

  int total = 0;
  int bad   = 0;

  int o_vec[3], o_fc[3], o_cex[3], o_busy[3], o_done[3], o_pass[3], o_csk[3];

  task automatic snap();
    o_vec[0] = int'(vec_a); o_vec[1] = int'(vec_b); o_vec[2] = int'(vec_c);
    o_fc[0]  = int'(fc_a);  o_fc[1]  = int'(fc_b);  o_fc[2]  = int'(fc_c);
    o_cex[0] = int'(cex_a); o_cex[1] = int'(cex_b); o_cex[2] = int'(cex_c);
    o_busy[0] = int'(busy_a); o_busy[1] = int'(busy_b); o_busy[2] = int'(busy_c);
    o_done[0] = int'(done_a); o_done[1] = int'(done_b); o_done[2] = int'(done_c);
    o_pass[0] = int'(pass_a); o_pass[1] = int'(pass_b); o_pass[2] = int'(pass_c);
    o_csk[0]  = int'(csk_a);  o_csk[1]  = int'(csk_b);  o_csk[2]  = int'(csk_c);
  endtask

  task automatic check(input string tag, input int id, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, id, obs, exp);
    end
  endtask

  // Reference: what a sweep over the current tables must report.
  task automatic expect_of(input int id, output int e_fc, output int e_cex,
                           output int e_csk, output int e_pass, output int e_done);
    int pop = 0;
    int f = -1;
    for (int v = 0; v < n_of[id]; v++) begin
      if (fail_t[id][v]) begin
        pop++;
        if (f < 0) f = v;
      end
    end
    e_fc   = (pop > cmax_of[id]) ? cmax_of[id] : pop;
    e_cex  = (f < 0) ? 0 : f;
    e_csk  = (f < 0) ? 0 : int'(sk_t[id][f]);
    e_pass = (pop == 0) ? 1 : 0;
    e_done = n_of[id] + lat_of[id] + 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (f >= 0) begin
      e_fc = 1;
      if (f + lat_of[id] + 3 < e_done) e_done = f + lat_of[id] + 3;
    end
`endif
  endtask

  // Fill tables: failures with probability p (percent) at vectors >= lo.
  task automatic fill(input int pa, input int loa, input int pb, input int lob,
                      input int pc, input int loc);
    for (int v = 0; v < 256; v++) begin
      fail_t[0][v] = (v >= loa) && (int'($urandom_range(99)) < pa);
      fail_t[1][v] = (v >= lob) && (int'($urandom_range(99)) < pb);
      fail_t[2][v] = (v < 32) && (v >= loc) && (int'($urandom_range(99)) < pc);
      for (int i = 0; i < 3; i++) sk_t[i][v] = 1'($urandom_range(1));
    end
  endtask

  // One sweep on all instances; optional re-pulse of start mid-sweep.
  task automatic run_sweep(input string nm, input bit mid);
    int done_at[3];
    int busy_n[3];
    int e_fc, e_cex, e_csk, e_pass, e_done;
    bit pulsed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_at[i] = 0;
      busy_n[i]  = 0;
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 1; j <= 320; j++) begin
      @(negedge clk);
      start = 1'b0;
      snap();
      if (j == 1) begin
        for (int i = 0; i < 3; i++) begin
          check("restart_vec", i, o_vec[i], 0);
          check("restart_done", i, o_done[i], 0);
          check("restart_fc", i, o_fc[i], 0);
          check("restart_cex", i, o_cex[i], 0);
          check("restart_pass", i, o_pass[i], 0);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (o_busy[i] != 0) busy_n[i]++;
        if (o_done[i] != 0 && done_at[i] == 0) done_at[i] = j;
      end
      if (mid && !pulsed && o_busy[0] != 0 && o_vec[0] == 16) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
    end
    start = 1'b0;
    if (mid) check("mid_pulse_issued", 0, int'(pulsed), 1);
    for (int i = 0; i < 3; i++) begin
      expect_of(i, e_fc, e_cex, e_csk, e_pass, e_done);
      check("done_cycle", i, done_at[i], e_done);
      check("busy_cycles", i, busy_n[i], e_done - 1);
      check("fail_count", i, o_fc[i], e_fc);
      check("cex_vec", i, o_cex[i], e_cex);
      check("cex_skolem", i, o_csk[i], e_csk);
      check("pass", i, o_pass[i], e_pass);
`ifndef SWEEP_STOP_ON_FAIL_EN
      check("vec_hold", i, o_vec[i], n_of[i] - 1);
`endif
    end
    $display("sweep %s: a fc=%0d cex=%0h done@%0d | b fc=%0d cex=%0h done@%0d | c fc=%0d cex=%0h done@%0d",
             nm, o_fc[0], o_cex[0], done_at[0], o_fc[1], o_cex[1], done_at[1],
             o_fc[2], o_cex[2], done_at[2]);
  endtask

  task automatic check_all_zero(input string tag);
    snap();
    for (int i = 0; i < 3; i++) begin
      check({tag, "_vec"}, i, o_vec[i], 0);
      check({tag, "_busy"}, i, o_busy[i], 0);
      check({tag, "_done"}, i, o_done[i], 0);
      check({tag, "_pass"}, i, o_pass[i], 0);
      check({tag, "_fc"}, i, o_fc[i], 0);
      check({tag, "_cex"}, i, o_cex[i], 0);
      check({tag, "_csk"}, i, o_csk[i], 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    fill(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Everything satisfied.
    run_sweep("all_pass", 1'b0);

    // Directed: A fails only at 8'hFF with skolem ~&v; B fails on odd
    // vectors; C fails at the first and last vector.
    for (int v = 0; v < 256; v++) begin
      fail_t[0][v] = (v == 255);
      sk_t[0][v]   = (v != 255);
      fail_t[1][v] = (v % 2) == 1;
      sk_t[1][v]   = 1'($urandom_range(1));
      fail_t[2][v] = (v == 0) || (v == 31);
      sk_t[2][v]   = 1'($urandom_range(1));
    end
    run_sweep("directed", 1'b0);

    // Random tables at a range of failure densities (C saturates at 7).
    for (int r = 0; r < 3; r++) begin
      fill(int'($urandom_range(30)), 0, int'($urandom_range(60)), 0,
           40 + int'($urandom_range(60)), 0);
      run_sweep("random", 1'b0);
    end

    // start re-pulsed while A issues 8'h10 must be ignored.
    fill(30, 128, 30, 128, 50, 20);
    run_sweep("mid_start", 1'b1);

    // Reset while A issues 8'h40 aborts everything.
    fill(50, 128, 50, 0, 50, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (vec_a == 8'h40 && busy_a) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_point_reached", 0, int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_rst");

    fill(0, 0, 0, 0, 0, 0);
    run_sweep("after_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
